// File: rtl/conv_pkg.sv
// Shared definitions for the 5x5 convolution sequencer: state encoding,
// kernel geometry and a width helper that keeps degenerate sizes legal.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int KSIZE  = 5;
  localparam int MARGIN = KSIZE - 1;

  // Counter width for n distinct values, never below one bit.
  function automatic int safe_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_cnt.sv
// 2-D wrap counter: x runs 0..XN-1, then wraps and bumps y (0..YN-1).
// last flags the final (XN-1, YN-1) position.
module raster_cnt
  import conv_pkg::*;
#(
  parameter int XN = 4,
  parameter int YN = 4,
  parameter int XW = safe_w(XN),
  parameter int YW = safe_w(YN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end_s, y_end_s;

  // Next position: clear wins, otherwise advance in raster order.
  always_comb begin
    x_end_s = (x_q == XW'(XN - 1));
    y_end_s = (y_q == YW'(YN - 1));
    x_d     = x_q;
    y_d     = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_end_s) begin
        x_d = '0;
        if (y_end_s) begin
          y_d = '0;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end_s && y_end_s;

endmodule

// File: rtl/conv5_sched.sv
// conv5_sched: walks every valid 5x5 window of an IMG_W x IMG_H map, issues
// 5 contiguous line-buffer column reads per window, meters issue against
// result-FIFO room and in-flight windows, tags returning results.
// Optional perf counters (perf_stall, perf_frame) under CONV5_SCHED_PERF_EN.
module conv5_sched
  import conv_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int RD_LAT    = 1,
  parameter int MAX_OUTST = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               rd_en,
  output logic [$clog2(IMG_H)-1:0]           rd_row,
  output logic [$clog2(IMG_W)-1:0]           rd_col,
  output logic                               f_in_valid,
  input  logic                               f_out_valid,
  input  logic                               res_afull,
  output logic [safe_w(IMG_W-MARGIN)-1:0]    out_x,
  output logic [safe_w(IMG_H-MARGIN)-1:0]    out_y
`ifdef CONV5_SCHED_PERF_EN
  ,
  output logic [31:0]                        perf_stall,
  output logic [31:0]                        perf_frame
`endif
);

  localparam int XN   = IMG_W - MARGIN;
  localparam int YN   = IMG_H - MARGIN;
  localparam int XW   = safe_w(XN);
  localparam int YW   = safe_w(YN);
  localparam int RRW  = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int NRES = XN * YN;
  localparam int NW   = $clog2(NRES + 1);
  localparam int OW   = $clog2(MAX_OUTST + 1);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [NW-1:0]     res_cnt_q, res_cnt_d;
  logic              res_full_q, res_full_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [RRW-1:0]    rd_row_q, rd_row_d;
  logic [CW-1:0]     rd_col_q, rd_col_d;
  logic [RD_LAT-1:0] dly_q, dly_d;

  logic [XW-1:0] ox_s;
  logic [YW-1:0] oy_s;
  logic          pos_last_s, res_last_s;
  logic          start_ok_s, iss_s, ret_s, room_s;

  // Frame events: accepted start, window completion, counted result, room to issue.
  always_comb begin
    start_ok_s = (state_q == IDLE) && start;
    iss_s      = (state_q == ISSUE) && (k_q == 3'(KSIZE - 1));
    ret_s      = f_out_valid && (state_q != IDLE) && (outst_q != '0) && !res_full_q;
    room_s     = !res_afull && (outst_q < OW'(MAX_OUTST));
  end

  raster_cnt #(.XN(XN), .YN(YN)) u_pos (
    .clk (clk), .rst (rst), .clr (start_ok_s), .adv (iss_s),
    .x   (ox_s), .y (oy_s), .last (pos_last_s)
  );

  raster_cnt #(.XN(XN), .YN(YN)) u_res (
    .clk (clk), .rst (rst), .clr (start_ok_s), .adv (ret_s),
    .x   (out_x), .y (out_y), .last (res_last_s)
  );

  // State sequencing; windows are admitted only from CHECK and run unbroken.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (room_s) begin
          state_d = ISSUE;
          k_d     = 3'd0;
        end else begin
          state_d = CHECK;
        end
      end
      ISSUE: begin
        if (iss_s) begin
          k_d     = 3'd0;
          state_d = pos_last_s ? DRAIN : CHECK;
        end else begin
          k_d     = k_q + 3'd1;
        end
      end
      DRAIN: begin
        if ((outst_q == '0) && (res_cnt_q == NW'(NRES))) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // In-flight window count and result bookkeeping.
  always_comb begin
    outst_d    = outst_q;
    res_cnt_d  = res_cnt_q;
    res_full_d = res_full_q;
    if (start_ok_s) begin
      outst_d    = '0;
      res_cnt_d  = '0;
      res_full_d = 1'b0;
    end else begin
      case ({iss_s, ret_s})
        2'b10:   outst_d = outst_q + OW'(1);
        2'b01:   outst_d = outst_q - OW'(1);
        default: outst_d = outst_q;
      endcase
      if (ret_s) begin
        res_cnt_d  = res_cnt_q + NW'(1);
        res_full_d = res_last_s;
      end else begin
        res_cnt_d  = res_cnt_q;
        res_full_d = res_full_q;
      end
    end
  end

  // Output look-ahead so every strobe and address leaves a flop.
  always_comb begin
    busy_d  = (state_d == CHECK) || (state_d == ISSUE) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == ISSUE);
    if (state_d == ISSUE) begin
      rd_row_d = RRW'(oy_s);
      rd_col_d = CW'(ox_s) + CW'(k_d);
    end else begin
      rd_row_d = '0;
      rd_col_d = '0;
    end
    dly_d    = '0;
    dly_d[0] = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 3'd0;
      outst_q    <= '0;
      res_cnt_q  <= '0;
      res_full_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      outst_q    <= outst_d;
      res_cnt_q  <= res_cnt_d;
      res_full_q <= res_full_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      dly_q      <= dly_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_row     = rd_row_q;
  assign rd_col     = rd_col_q;
  assign f_in_valid = dly_q[RD_LAT-1];

`ifdef CONV5_SCHED_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_frame_q, perf_frame_d;

  // Saturating stall and frame-length counters, cleared on an accepted start.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_frame_d = perf_frame_q;
    if (start_ok_s) begin
      perf_stall_d = 32'd0;
      perf_frame_d = 32'd0;
    end else begin
      if ((state_q == CHECK) && !room_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end else begin
        perf_stall_d = perf_stall_q;
      end
      if (busy_q && (perf_frame_q != 32'hFFFF_FFFF)) begin
        perf_frame_d = perf_frame_q + 32'd1;
      end else begin
        perf_frame_d = perf_frame_q;
      end
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_frame_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_frame_q <= perf_frame_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_frame = perf_frame_q;
`endif

endmodule

// File: tb/tb_conv5_sched.sv
// Randomized scoreboard bench for conv5_sched on an 8x7 map, RD_LAT=3.
module tb_conv5_sched;

  localparam int W = 8, H = 7, LAT = 3, MAXO = 2;
  localparam int XN = W - 4, YN = H - 4, NWIN = XN * YN;

  logic clk, rst, start, f_out_valid, res_afull;
  logic busy, done, rd_en, f_in_valid;
  logic [$clog2(H)-1:0]  rd_row;
  logic [$clog2(W)-1:0]  rd_col;
  logic [$clog2(XN)-1:0] out_x;
  logic [$clog2(YN)-1:0] out_y;

  int total = 0, bad = 0;
  int mon_dones = 0, frames_exp = 0;
  int lat_lo = 2, lat_hi = 2;
  int ex_q[$], ey_q[$];

  conv5_sched #(.IMG_W(W), .IMG_H(H), .RD_LAT(LAT), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .f_in_valid(f_in_valid),
    .f_out_valid(f_out_valid), .res_afull(res_afull), .out_x(out_x), .out_y(out_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Filter model: one result per 5 f_in_valid beats, random latency, in order.
  initial begin : filt
    int fcyc, fbeat, sched, last_due, lat, due;
    int due_q[$];
    fcyc = 0; fbeat = 0; sched = 0; last_due = 0;
    f_out_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      fcyc++;
      if (rst) begin
        fbeat = 0; sched = 0;
        due_q.delete(); ex_q.delete(); ey_q.delete();
        f_out_valid = 1'b0;
      end else begin
        if (f_in_valid) begin
          fbeat++;
          if (fbeat == 5) begin
            fbeat = 0;
            lat = $urandom_range(lat_hi, lat_lo);
            due = fcyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
            ex_q.push_back(sched % XN);
            ey_q.push_back(sched / XN);
            sched = (sched + 1) % NWIN;
          end
        end
        if (due_q.size() > 0 && due_q[0] == fcyc) begin
          f_out_valid = 1'b1;
          void'(due_q.pop_front());
        end else begin
          f_out_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: checks read addresses, window admission, alignment, result tags, done.
  initial begin : mon
    int cyc, win, beat, outst, outst_p, results, last_start, issued;
    logic rst_p, afull_p;
    logic [LAT-1:0] hist;
    cyc = 0; win = 0; beat = 0; outst = 0; outst_p = 0; results = 0; last_start = 0;
    rst_p = 1'b0; afull_p = 1'b0; hist = '0;
    forever begin
      @(negedge clk);
      cyc++;
      issued = 0;
      if (rst_p) begin
        chk("reset_state", int'({busy, done, rd_en, f_in_valid, rd_row, rd_col, out_x, out_y}), 0);
        win = 0; beat = 0; outst = 0; outst_p = 0; results = 0;
        hist = '0;
      end else begin
        chk("f_in_valid_align", int'(f_in_valid), int'(hist[LAT-1]));
        if (beat != 0) begin
          chk("window_contiguous", int'(rd_en), 1);
        end else if (rd_en) begin
          chk("window_budget", int'(win < NWIN), 1);
          chk("issue_afull_clear", int'(afull_p), 0);
          chk("issue_outst_room", int'(outst_p < MAXO), 1);
          if (win > 0) chk("window_spacing", int'((cyc - last_start) >= 6), 1);
          last_start = cyc;
        end
        if (rd_en) begin
          chk("rd_row", int'(rd_row), win / XN);
          chk("rd_col", int'(rd_col), (win % XN) + beat);
          chk("busy_in_issue", int'(busy), 1);
          beat++;
          if (beat == 5) begin
            beat = 0; win++; issued = 1;
          end
        end
        if (f_out_valid) begin
          chk("result_expected", int'(ex_q.size() > 0), 1);
          if (ex_q.size() > 0) begin
            chk("out_x", int'(out_x), ex_q.pop_front());
            chk("out_y", int'(out_y), ey_q.pop_front());
            results++;
          end
        end
        outst_p = outst;
        outst = outst + issued - int'(f_out_valid);
        if (done) begin
          chk("done_windows", win, NWIN);
          chk("done_results", results, NWIN);
          chk("done_outst", outst, 0);
          chk("done_busy", int'(busy), 0);
          mon_dones++;
          win = 0; results = 0; beat = 0;
        end
      end
      hist = {hist[LAT-2:0], rd_en};
      afull_p = res_afull;
      rst_p = rst;
    end
  end

  // mode 0: clean, 1: 20-cycle afull hold before window 3, 2: random afull and starts
  task automatic run_frame(input int mode, input int lo, input int hi);
    int beats, hold, rel_c;
    bit got, held, kicked;
    lat_lo = lo; lat_hi = hi; frames_exp++;
    res_afull = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    beats = 0; hold = 0; rel_c = -100; got = 0; held = 0; kicked = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      start = 1'b0;
      if (rd_en) begin
        beats++;
        if (mode == 1 && beats == 11) chk("bp_resume_cycle", c, rel_c + 1);
      end
      if (done) begin
        got = 1;
      end else begin
        if (mode == 1) begin
          if (beats == 10 && !held) begin
            held = 1; hold = 20; res_afull = 1'b1;
          end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin res_afull = 1'b0; rel_c = c; end
          end
        end else if (mode == 2) begin
          res_afull = ($urandom_range(3, 0) == 0);
          if (busy && $urandom_range(7, 0) == 0) start = 1'b1;
        end
        if (beats == NWIN * 5 && !rd_en && busy && !kicked) begin
          start = 1'b1; kicked = 1;
        end
      end
      tick();
    end
    start = 1'b0; res_afull = 1'b0;
    chk("frame_done_seen", int'(got), 1);
    chk("done_count", mon_dones, frames_exp);
    tick();
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_pulse", int'(done), 0);
  endtask

  // Reset on the second beat of the fifth window; frame must not complete.
  task automatic abort_frame();
    int beats;
    bit hit;
    lat_lo = 2; lat_hi = 4; res_afull = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    beats = 0; hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (rd_en) beats++;
      if (beats == 22) begin
        rst = 1'b1; hit = 1;
      end
      tick();
    end
    rst = 1'b0;
    chk("abort_reached", int'(hit), 1);
    repeat (30) tick();
    chk("abort_no_done", mon_dones, frames_exp);
    chk("abort_idle", int'(busy), 0);
  endtask

  initial begin : main
    rst = 1'b1; start = 1'b0; res_afull = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    run_frame(1, 2, 2);
    run_frame(2, 1, 20);
    abort_frame();
    run_frame(0, 2, 6);
    run_frame(2, 1, 20);
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
